// File: rtl/alu_op_sequencer.sv
// Loads A, B, then opcode from a shared switch bus via debounced buttons, drives the ALU, and latches its result.
// Latency: load on edge DEBOUNCE_CYCLES+2 of a held button; capture ALU_LAT+1 edges after opcode load; no backpressure.
module alu_op_sequencer #(
  parameter int N_BITS          = 6,
  parameter int N_LEDS          = 6,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ALU_LAT         = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_sw,
  input  logic              i_btn_a,
  input  logic              i_btn_b,
  input  logic              i_btn_op,
  input  logic [N_LEDS-1:0] i_res,
  output logic [N_BITS-1:0] o_A,
  output logic [N_BITS-1:0] o_B,
  output logic [N_BITS-1:0] o_OP,
  output logic [N_LEDS-1:0] o_leds,
  output logic              o_valid,
  output logic              o_err,
  output logic [2:0]        o_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_HIT = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state;
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    btn_s;
  logic [2:0]    press;
  logic [CW-1:0] cnt [3];
  logic [WW-1:0] wcnt;

  assign raw = {i_btn_op, i_btn_b, i_btn_a};

  // Counter saturates above the hit value, so a long hold yields a single press.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      btn_s <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      btn_s <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (!btn_s[i])
          cnt[i] <= '0;
        else if (cnt[i] != CNT_MAX)
          cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_press
    assign press[g] = btn_s[g] && (cnt[g] == CNT_HIT);
  end

  function automatic logic op_ok(input logic [N_BITS-1:0] op);
    case (op)
      N_BITS'(6'b100000), N_BITS'(6'b100010), N_BITS'(6'b100100),
      N_BITS'(6'b100101), N_BITS'(6'b100110), N_BITS'(6'b000011),
      N_BITS'(6'b000010), N_BITS'(6'b100111): op_ok = 1'b1;
      default:                                op_ok = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= LOAD_A;
      o_A     <= '0;
      o_B     <= '0;
      o_OP    <= '0;
      o_leds  <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      wcnt    <= '0;
    end else begin
      case (state)
        LOAD_A: if (press[0]) begin
          o_A   <= i_sw;
          state <= LOAD_B;
        end
        LOAD_B: if (press[1]) begin
          o_B   <= i_sw;
          state <= LOAD_OP;
        end
        LOAD_OP: if (press[2]) begin
          o_OP    <= i_sw;
          o_valid <= 1'b0;
          o_err   <= 1'b0;
          wcnt    <= WW'(ALU_LAT);
          state   <= EXEC;
        end
        EXEC: begin
          if (wcnt == '0) begin
            if (op_ok(o_OP)) begin
              o_leds  <= i_res;
              o_valid <= 1'b1;
            end else begin
              o_leds <= '0;
              o_err  <= 1'b1;
            end
            state <= DONE;
          end else begin
            wcnt <= wcnt - WW'(1);
          end
        end
        DONE: if (press[0]) begin
          o_A     <= i_sw;
          o_valid <= 1'b0;
          o_err   <= 1'b0;
          state   <= LOAD_B;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  assign o_state = state;

endmodule
